ace_ps2_keyboard: RTL and testbench

//   PS/2 keyboard front end for the Jupiter Ace core. Deserialises PS/2 set-2

---
 rtl/ace_ps2_keyboard.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_ace_ps2_keyboard.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ace_ps2_keyboard.sv
// ---------------------------------------------------------------------------
// ace_ps2_keyboard
//   PS/2 keyboard front end for the Jupiter Ace core. Receives PS/2 set-2
//   scan codes, turns make/break sequences into an 8x5 key matrix, and answers
//   the CPU keyboard port read with active-low column bits.
//
// Ports
//   clk         in   1  system clock, shared with the core
//   reset_n     in   1  asynchronous reset, active low
//   ps2_clk     in   1  raw PS/2 clock (asynchronous to clk)
//   ps2_data    in   1  raw PS/2 data (asynchronous to clk)
//   kbd_row     in   8  row select, active low; bit r selects Ace row r
//   kbd_col     out  5  column state, active low, combinational
//   key_strobe  out  1  one-cycle pulse per valid received byte
//   rx_err      out  1  one-cycle pulse on parity or stop-bit error
// ---------------------------------------------------------------------------
module ace_ps2_keyboard #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] kbd_row,
  output logic [4:0] kbd_col,
  output logic       key_strobe,
  output logic       rx_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

  // Good frame: odd number of ones across data and parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  // Matrix entry encoding used by the lookup: {hit, backspace, index[5:0]}.
  function automatic logic [7:0] key_at(input int row, input int col);
    return {2'b10, 6'(row * 5 + col)};
  endfunction

  // Set-2 scan code to matrix position; returns 8'h00 for unmapped codes.
  function automatic logic [7:0] lookup(input logic [7:0] code, input logic ext);
    logic [7:0] res;
    res = 8'h00;
    if (ext) begin
      case (code)
        8'h14:   res = key_at(0, 1);   // right CTRL -> SYM
        8'h5A:   res = key_at(6, 0);   // keypad ENTER
        default: res = 8'h00;          // arrows and other extended keys ignored
      endcase
    end else begin
      case (code)
        8'h12, 8'h59: res = key_at(0, 0);
        8'h14: res = key_at(0, 1);
        8'h1A: res = key_at(0, 2);
        8'h22: res = key_at(0, 3);
        8'h21: res = key_at(0, 4);
        8'h1C: res = key_at(1, 0);
        8'h1B: res = key_at(1, 1);
        8'h23: res = key_at(1, 2);
        8'h2B: res = key_at(1, 3);
        8'h34: res = key_at(1, 4);
        8'h15: res = key_at(2, 0);
        8'h1D: res = key_at(2, 1);
        8'h24: res = key_at(2, 2);
        8'h2D: res = key_at(2, 3);
        8'h2C: res = key_at(2, 4);
        8'h16: res = key_at(3, 0);
        8'h1E: res = key_at(3, 1);
        8'h26: res = key_at(3, 2);
        8'h25: res = key_at(3, 3);
        8'h2E: res = key_at(3, 4);
        8'h45: res = key_at(4, 0);
        8'h46: res = key_at(4, 1);
        8'h3E: res = key_at(4, 2);
        8'h3D: res = key_at(4, 3);
        8'h36: res = key_at(4, 4);
        8'h4D: res = key_at(5, 0);
        8'h44: res = key_at(5, 1);
        8'h43: res = key_at(5, 2);
        8'h3C: res = key_at(5, 3);
        8'h35: res = key_at(5, 4);
        8'h5A: res = key_at(6, 0);
        8'h4B: res = key_at(6, 1);
        8'h42: res = key_at(6, 2);
        8'h3B: res = key_at(6, 3);
        8'h33: res = key_at(6, 4);
        8'h29: res = key_at(7, 0);
        8'h3A: res = key_at(7, 1);
        8'h31: res = key_at(7, 2);
        8'h32: res = key_at(7, 3);
        8'h2A: res = key_at(7, 4);
        8'h66: res = 8'hC0;            // BACKSPACE: separate bit
        default: res = 8'h00;
      endcase
    end
    return res;
  endfunction

  // Synchroniser and glitch filter state
  logic          clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
  logic          clk_meta_d, clk_sync_d, dat_meta_d, dat_sync_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          filt_clk_q, filt_clk_d;
  logic          fall_s;

  // Receiver state
  rx_state_t     state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] tmo_q;
  logic          byte_valid_q;
  logic [7:0]    byte_q;
  logic          rx_err_q;

  // Decoder / matrix state
  logic [39:0]   key_q, key_d;
  logic          bksp_q, bksp_d;
  logic          rel_q, rel_d;
  logic          ext_q, ext_d;
  logic          strobe_q, strobe_d;
  logic [7:0]    hit_s;
  logic [4:0]    any_s;

  // Next-state for the synchronisers and the PS/2 clock filter.
  always_comb begin
    clk_meta_d = ps2_clk;
    clk_sync_d = clk_meta_q;
    dat_meta_d = ps2_data;
    dat_sync_d = dat_meta_q;
    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    if (clk_sync_q != filt_clk_q) begin
      // Flip only on the FILTER_LEN-th consecutive differing sample.
      if (filt_cnt_q == FILT_LAST) begin
        filt_clk_d = clk_sync_q;
        filt_cnt_d = '0;
      end else begin
        filt_cnt_d = filt_cnt_q + FW'(1);
      end
    end else begin
      filt_cnt_d = '0;
    end
  end

  // Falling edge of the filtered clock; the receiver steps on this cycle.
  assign fall_s = filt_clk_q & ~filt_clk_d;

  // Synchroniser and filter registers; PS/2 lines idle high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      filt_cnt_q <= '0;
      filt_clk_q <= 1'b1;
    end else begin
      clk_meta_q <= clk_meta_d;
      clk_sync_q <= clk_sync_d;
      dat_meta_q <= dat_meta_d;
      dat_sync_q <= dat_sync_d;
      filt_cnt_q <= filt_cnt_d;
      filt_clk_q <= filt_clk_d;
    end
  end

  // Frame receiver: start / 8 data / parity / stop, with mid-frame timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      byte_valid_q <= 1'b0;
      byte_q       <= 8'h00;
      rx_err_q     <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      rx_err_q     <= 1'b0;
      if (state_q == ST_IDLE) begin
        tmo_q <= '0;
        if (fall_s && !dat_sync_q) begin
          state_q   <= ST_DATA;
          bit_cnt_q <= 3'd0;
        end
      end else if (fall_s) begin
        tmo_q <= '0;
        case (state_q)
          ST_DATA: begin
            shift_q   <= {dat_sync_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            par_q   <= dat_sync_q;
            state_q <= ST_STOP;
          end
          ST_STOP: begin
            if (odd_parity_ok(shift_q, par_q) && dat_sync_q) begin
              byte_valid_q <= 1'b1;
              byte_q       <= shift_q;
            end else begin
              rx_err_q <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (tmo_q == TMO_LAST) begin
        // Stalled frame: abandon it silently.
        state_q <= ST_IDLE;
        tmo_q   <= '0;
      end else begin
        tmo_q <= tmo_q + TW'(1);
      end
    end
  end

  // Scan-code decoder: prefix flags and key matrix updates.
  always_comb begin
    key_d    = key_q;
    bksp_d   = bksp_q;
    rel_d    = rel_q;
    ext_d    = ext_q;
    strobe_d = byte_valid_q;
    hit_s    = 8'h00;
    if (byte_valid_q) begin
      case (byte_q)
        8'hF0: rel_d = 1'b1;
        8'hE0: ext_d = 1'b1;
        8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF: begin
          rel_d = 1'b0;
          ext_d = 1'b0;
        end
        default: begin
          hit_s = lookup(byte_q, ext_q);
          if (hit_s[7]) begin
            if (hit_s[6]) begin
              bksp_d = ~rel_q;
            end else begin
              key_d[hit_s[5:0]] = ~rel_q;
            end
          end else begin
            key_d = key_q;
          end
          rel_d = 1'b0;
          ext_d = 1'b0;
        end
      endcase
    end else begin
      hit_s = 8'h00;
    end
  end

  // Decoder registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q    <= 40'h0;
      bksp_q   <= 1'b0;
      rel_q    <= 1'b0;
      ext_q    <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      key_q    <= key_d;
      bksp_q   <= bksp_d;
      rel_q    <= rel_d;
      ext_q    <= ext_d;
      strobe_q <= strobe_d;
    end
  end

  // Column read: OR the selected rows; BACKSPACE appears as SHIFT+0.
  always_comb begin
    any_s = 5'b00000;
    for (int r = 0; r < 8; r++) begin
      if (!kbd_row[r]) begin
        any_s = any_s | key_q[r*5 +: 5] | (((r == 0) || (r == 4)) ? {4'b0000, bksp_q} : 5'b00000);
      end else begin
        any_s = any_s;
      end
    end
    kbd_col = ~any_s;
  end

  assign key_strobe = strobe_q;
  assign rx_err     = rx_err_q;

endmodule

// File: tb/tb_ace_ps2_keyboard.sv
module tb_ace_ps2_keyboard;

  localparam int FILT = 8;
  localparam int TMO  = 1000;
  localparam int HALF = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] kbd_row = 8'hFF;
  logic [4:0] kbd_col;
  logic       key_strobe;
  logic       rx_err;

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;

  // Reference model: matrix position per scan code, -1 if unmapped.
  int norm_map [256];
  int ext_map  [256];
  bit m_key [40];
  bit m_bksp, m_rel, m_ext;
  logic [7:0] pool [$];
  logic [7:0] mat_codes [40] = '{
    8'h12, 8'h14, 8'h1A, 8'h22, 8'h21,
    8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
    8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
    8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
    8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36,
    8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
    8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33,
    8'h29, 8'h3A, 8'h31, 8'h32, 8'h2A};
  logic [7:0] specials [5] = '{8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF};
  logic [7:0] ext_codes [4] = '{8'h14, 8'h5A, 8'h75, 8'h6B};

  ace_ps2_keyboard #(.FILTER_LEN(FILT), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .kbd_row(kbd_row), .kbd_col(kbd_col), .key_strobe(key_strobe), .rx_err(rx_err));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_strobe === 1'b1) strobe_cnt++;
    if (rx_err === 1'b1) err_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    foreach (m_key[i]) m_key[i] = 1'b0;
    m_bksp = 1'b0; m_rel = 1'b0; m_ext = 1'b0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int idx;
    if (b == 8'hF0) m_rel = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (b inside {8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF}) begin
      m_rel = 1'b0; m_ext = 1'b0;
    end else begin
      if (m_ext) idx = ext_map[b];
      else if (b == 8'h66) idx = 40;
      else idx = norm_map[b];
      if (idx == 40) m_bksp = !m_rel;
      else if (idx >= 0) m_key[idx] = !m_rel;
      m_rel = 1'b0; m_ext = 1'b0;
    end
  endfunction

  function automatic logic [4:0] exp_col(input logic [7:0] row);
    logic [4:0] any;
    any = 5'b0;
    for (int r = 0; r < 8; r++)
      if (!row[r])
        for (int c = 0; c < 5; c++)
          if (m_key[r*5+c] || (m_bksp && c == 0 && (r == 0 || r == 4))) any[c] = 1'b1;
    return ~any;
  endfunction

  function automatic logic [10:0] frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    p = (~^b) ^ bad_par;
    return {~bad_stop, p, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      cyc(HALF);
      ps2_clk = 1'b0;
      cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    cyc(HALF);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int s0, e0;
    s0 = strobe_cnt; e0 = err_cnt;
    send_bits(frame(b, 1'b0, 1'b0), 11);
    model_byte(b);
    check($sformatf("strobe_%02h", b), strobe_cnt - s0, 1);
    check($sformatf("noerr_%02h", b), err_cnt - e0, 0);
  endtask

  task automatic check_row(input string tag, input logic [7:0] row);
    kbd_row = row;
    #1;
    check(tag, {27'b0, kbd_col}, {27'b0, exp_col(row)});
  endtask

  initial begin
    int s0, e0, sel;
    logic [7:0] b;
    for (int i = 0; i < 256; i++) begin norm_map[i] = -1; ext_map[i] = -1; end
    for (int i = 0; i < 40; i++) begin norm_map[mat_codes[i]] = i; pool.push_back(mat_codes[i]); end
    norm_map[8'h59] = 0; pool.push_back(8'h59); pool.push_back(8'h66);
    ext_map[8'h14] = 1; ext_map[8'h5A] = 30;
    model_reset();

    // 1. reset state
    kbd_row = 8'h00;
    cyc(3);
    reset_n = 1'b1;
    cyc(20);
    check("reset_col", {27'b0, kbd_col}, 32'h1F);
    check("reset_strobe", strobe_cnt, 0);
    check("reset_err", err_cnt, 0);

    // 2. A press / release
    send_byte(8'h1C);
    kbd_row = 8'hFD; #1;
    check("a_press", {27'b0, kbd_col}, 32'h1E);
    send_byte(8'hF0); send_byte(8'h1C);
    check_row("a_release", 8'hFD);

    // 3. SHIFT held, BACKSPACE on top
    send_byte(8'h12); send_byte(8'h66);
    kbd_row = 8'hFE; #1; check("bs_r0", {27'b0, kbd_col}, 32'h1E);
    kbd_row = 8'hEF; #1; check("bs_r4", {27'b0, kbd_col}, 32'h1E);
    send_byte(8'hF0); send_byte(8'h66);
    kbd_row = 8'hFE; #1; check("shift_kept", {27'b0, kbd_col}, 32'h1E);
    kbd_row = 8'hEF; #1; check("bs_gone", {27'b0, kbd_col}, 32'h1F);
    send_byte(8'hF0); send_byte(8'h12);
    check_row("shift_rel", 8'h00);

    // 4. bad parity, bad stop
    s0 = strobe_cnt; e0 = err_cnt;
    send_bits(frame(8'h1C, 1'b1, 1'b0), 11);
    check("par_err", err_cnt - e0, 1);
    check("par_nostrobe", strobe_cnt - s0, 0);
    check_row("par_matrix", 8'h00);
    s0 = strobe_cnt; e0 = err_cnt;
    send_bits(frame(8'h1C, 1'b0, 1'b1), 11);
    check("stop_err", err_cnt - e0, 1);
    check("stop_nostrobe", strobe_cnt - s0, 0);
    check_row("stop_matrix", 8'h00);

    // 5. timeout, then SPACE; extended arrow ignored
    e0 = err_cnt;
    send_bits(frame(8'h55, 1'b0, 1'b0), 5);
    cyc(TMO + 1);
    check("tmo_noerr", err_cnt - e0, 0);
    send_byte(8'h29);
    kbd_row = 8'h7F; #1; check("space", {27'b0, kbd_col}, 32'h1E);
    send_byte(8'hE0); send_byte(8'h75);
    check_row("arrow", 8'h00);
    send_byte(8'h1C);
    check_row("flags_clear", 8'hFD);

    // 6. sub-filter glitch, reset mid-frame
    s0 = strobe_cnt; e0 = err_cnt;
    ps2_data = 1'b0;
    ps2_clk = 1'b0;
    cyc(FILT - 1);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    cyc(3 * HALF);
    check("glitch_nostrobe", strobe_cnt - s0, 0);
    check("glitch_noerr", err_cnt - e0, 0);
    send_byte(8'h1A);
    check_row("after_glitch", 8'hFE);
    send_bits(frame(8'h16, 1'b0, 1'b0), 5);
    kbd_row = 8'h00;
    ps2_data = 1'b0;
    ps2_clk = 1'b0;
    cyc(HALF);
    reset_n = 1'b0;
    #1;
    check("reset_mid", {27'b0, kbd_col}, 32'h1F);
    model_reset();
    ps2_clk = 1'b1; ps2_data = 1'b1;
    cyc(3);
    reset_n = 1'b1;
    cyc(HALF);
    send_byte(8'h4D);
    check_row("after_reset", 8'hDF);

    // Randomized make/break traffic against the model
    for (int it = 0; it < 30; it++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5) begin
        if ($urandom_range(0, 1) == 1) send_byte(8'hF0);
        send_byte(pool[$urandom_range(0, pool.size() - 1)]);
      end else if (sel == 6) begin
        send_byte(8'hE0);
        if ($urandom_range(0, 1) == 1) send_byte(8'hF0);
        send_byte(ext_codes[$urandom_range(0, 3)]);
      end else if (sel == 7) begin
        send_byte(($urandom_range(0, 1) == 1) ? 8'hF0 : 8'hE0);
        send_byte(specials[$urandom_range(0, 4)]);
      end else if (sel == 8) begin
        b = ($urandom_range(0, 1) == 1) ? 8'h0E : 8'h76;
        send_byte(b);
      end else begin
        send_byte(($urandom_range(0, 1) == 1) ? 8'hF0 : 8'hE0);
      end
      check_row($sformatf("rand%0d_rowr", it), 8'($urandom_range(0, 255)));
      check_row($sformatf("rand%0d_all", it), 8'h00);
      check_row($sformatf("rand%0d_none", it), 8'hFF);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
